// File: rtl/scene_query_multi_pkg.sv
// Shared types and IEEE-754 single-precision helpers for the multi-object scene query.
package scene_query_multi_pkg;

  typedef logic [31:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  typedef enum logic [1:0] {
    SPHERE = 2'd0,
    CUBE   = 2'd1,
    PLANE  = 2'd2,
    RSVD   = 2'd3
  } obj_type_e;

  typedef struct packed {
    logic      en;
    obj_type_e obj_type;
    vec3_t     center;
    fp_t       size;
  } obj_t;

  localparam fp_t FP_MAX_DIST = 32'h42C80000;

  function automatic logic fp_is_nan(input fp_t a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction

  // Sign-magnitude strict less-than; NaN never compares less and both zeros are equal.
  function automatic logic fp_lt(input fp_t a, input fp_t b);
    logic a_zero;
    logic b_zero;
    if (fp_is_nan(a) || fp_is_nan(b)) return 1'b0;
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (a_zero && b_zero) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

endpackage

// File: rtl/scene_query_multi_mask_walker.sv
// Finds the next set bit of a mask above (or, with incl_i, at) the current index.
module scene_query_multi_mask_walker #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] cur_i,
  input  logic             incl_i,
  output logic [IDX_W-1:0] next_o,
  output logic             last_o
);

  always_comb begin
    next_o = IDX_W'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i] && ((IDX_W'(i) > cur_i) || (incl_i && (IDX_W'(i) == cur_i)))) begin
        next_o = IDX_W'(i);
      end
    end
    last_o = (next_o == IDX_W'(N));
  end

endmodule

// File: rtl/scene_query_multi.sv
// Object-table scene query: streams (pos, object) requests to an in-order SDF evaluator
// and min-reduces the returned distances into closest distance, winning index and hit.
module scene_query_multi
  import scene_query_multi_pkg::*;
#(
  parameter int  NUM_OBJ  = 8,
  parameter int  IDX_W    = $clog2(NUM_OBJ + 1),
  parameter fp_t MAX_DIST = 32'h42C80000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  obj_t               cfg_obj,
  input  logic               in_valid,
  output logic               in_ready,
  input  vec3_t              pos,
  input  logic [NUM_OBJ-1:0] obj_mask,
  output logic               sdf_req_valid,
  input  logic               sdf_req_ready,
  output vec3_t              sdf_req_pos,
  output obj_t               sdf_req_obj,
  input  logic               sdf_rsp_valid,
  input  fp_t                sdf_rsp_dist,
  output logic               out_valid,
  input  logic               out_ready,
  output fp_t                closest_dist,
  output logic [IDX_W-1:0]   closest_idx,
  output logic               hit
);

  localparam int PTR_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NUM_OBJ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  obj_t               tbl_q [NUM_OBJ];
  vec3_t              pos_q, pos_d;
  logic [NUM_OBJ-1:0] act_q, act_d;
  logic [IDX_W-1:0]   iss_ptr_q, iss_ptr_d;
  logic [IDX_W-1:0]   rsp_ptr_q, rsp_ptr_d;
  logic               req_vld_q, req_vld_d;
  fp_t                best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               hit_q, hit_d;

  logic [NUM_OBJ-1:0] en_vec;
  logic [NUM_OBJ-1:0] walk_mask;
  logic               idle;
  logic [IDX_W-1:0]   iss_next, rsp_next;
  logic               iss_last, rsp_last;

  always_comb begin
    en_vec = '0;
    for (int i = 0; i < NUM_OBJ; i++) en_vec[i] = tbl_q[i].en;
  end

  assign idle = (state_q == S_IDLE);
  // In IDLE the issue walker looks at the incoming mask to find the first entry.
  assign walk_mask = idle ? (obj_mask & en_vec) : act_q;

  scene_query_multi_mask_walker #(.N(NUM_OBJ), .IDX_W(IDX_W)) u_iss_walk (
    .mask_i (walk_mask),
    .cur_i  (idle ? '0 : iss_ptr_q),
    .incl_i (idle),
    .next_o (iss_next),
    .last_o (iss_last)
  );

  scene_query_multi_mask_walker #(.N(NUM_OBJ), .IDX_W(IDX_W)) u_rsp_walk (
    .mask_i (act_q),
    .cur_i  (rsp_ptr_q),
    .incl_i (1'b0),
    .next_o (rsp_next),
    .last_o (rsp_last)
  );

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    act_d      = act_q;
    iss_ptr_d  = iss_ptr_q;
    rsp_ptr_d  = rsp_ptr_q;
    req_vld_d  = req_vld_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    hit_d      = hit_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        pos_d      = pos;
        act_d      = walk_mask;
        best_d     = MAX_DIST;
        best_idx_d = IDX_NONE;
        hit_d      = 1'b0;
        if (walk_mask == '0) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_RUN;
          iss_ptr_d = iss_next;
          rsp_ptr_d = iss_next;
          req_vld_d = 1'b1;
        end
      end
      S_RUN: begin
        if (req_vld_q && sdf_req_ready) begin
          if (iss_last) req_vld_d = 1'b0;
          else          iss_ptr_d = iss_next;
        end
        if (sdf_rsp_valid) begin
          hit_d = 1'b1;
          if (fp_lt(sdf_rsp_dist, best_q)) begin
            best_d     = sdf_rsp_dist;
            best_idx_d = rsp_ptr_q;
          end
          if (rsp_last) begin
            state_d   = S_DONE;
            req_vld_d = 1'b0;
          end else begin
            rsp_ptr_d = rsp_next;
          end
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      act_q      <= '0;
      iss_ptr_q  <= '0;
      rsp_ptr_q  <= '0;
      req_vld_q  <= 1'b0;
      best_q     <= MAX_DIST;
      best_idx_q <= IDX_NONE;
      hit_q      <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) tbl_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      act_q      <= act_d;
      iss_ptr_q  <= iss_ptr_d;
      rsp_ptr_q  <= rsp_ptr_d;
      req_vld_q  <= req_vld_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      hit_q      <= hit_d;
      if (cfg_we && idle && (cfg_idx < IDX_NONE)) tbl_q[cfg_idx[PTR_W-1:0]] <= cfg_obj;
    end
  end

  assign cfg_ready     = idle;
  assign in_ready      = idle;
  assign out_valid     = (state_q == S_DONE);
  assign sdf_req_valid = req_vld_q;
  assign sdf_req_pos   = pos_q;
  assign sdf_req_obj   = tbl_q[iss_ptr_q[PTR_W-1:0]];
  assign closest_dist  = best_q;
  assign closest_idx   = best_idx_q;
  assign hit           = hit_q;

endmodule

// File: tb/tb_scene_query_multi.sv
// Directed and randomized checks of scene_query_multi against a table-level reference model.
module tb_scene_query_multi;
  import scene_query_multi_pkg::*;

  localparam int N = 8;
  localparam int IW = 4;
  localparam logic [31:0] MAXD = 32'h42C80000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic cfg_ready;
  logic [IW-1:0] cfg_idx = '0;
  obj_t cfg_obj = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  vec3_t pos = '0;
  logic [N-1:0] obj_mask = '0;
  logic sdf_req_valid;
  logic sdf_req_ready = 1'b0;
  vec3_t sdf_req_pos;
  obj_t sdf_req_obj;
  logic sdf_rsp_valid = 1'b0;
  logic [31:0] sdf_rsp_dist = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] closest_dist;
  logic [IW-1:0] closest_idx;
  logic hit;

  scene_query_multi #(.NUM_OBJ(N), .IDX_W(IW), .MAX_DIST(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_obj(cfg_obj), .in_valid(in_valid), .in_ready(in_ready),
    .pos(pos), .obj_mask(obj_mask), .sdf_req_valid(sdf_req_valid),
    .sdf_req_ready(sdf_req_ready), .sdf_req_pos(sdf_req_pos), .sdf_req_obj(sdf_req_obj),
    .sdf_rsp_valid(sdf_rsp_valid), .sdf_rsp_dist(sdf_rsp_dist), .out_valid(out_valid),
    .out_ready(out_ready), .closest_dist(closest_dist), .closest_idx(closest_idx), .hit(hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail = 0;
  int lat = 1;
  int rdy_mode = 0;
  obj_t mdl [N];

  // Evaluator model: returns the descriptor's size field as the distance, lat cycles after issue.
  int due_q[$];
  logic [31:0] dist_q[$];
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: sdf_req_ready = 1'b1;
      1: sdf_req_ready = (cyc % 2 == 0);
      default: sdf_req_ready = 1'($urandom_range(0, 1));
    endcase
    if (sdf_req_valid && sdf_req_ready) begin
      due_q.push_back(cyc + lat);
      dist_q.push_back(sdf_req_obj.size);
    end
    while (due_q.size() > 0 && due_q[0] < cyc) begin
      void'(due_q.pop_front());
      void'(dist_q.pop_front());
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      sdf_rsp_dist = dist_q.pop_front();
      sdf_rsp_valid = 1'b1;
    end else begin
      sdf_rsp_valid = 1'b0;
      sdf_rsp_dist = $urandom;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Total order key of a float: signed magnitude, both zeros map to 0.
  function automatic longint fkey(input logic [31:0] f);
    return f[31] ? -longint'(f[30:0]) : longint'(f[30:0]);
  endfunction

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 9))
      0: return 32'h7FC00000 | 32'($urandom_range(0, 255));
      1: return 32'h80000000;
      2: return 32'h00000000;
      3: return MAXD;
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(118, 136)), 23'($urandom)};
    endcase
  endfunction

  task automatic write_cfg(input int idx, input logic en, input logic [31:0] size);
    obj_t o;
    o.en = en;
    o.obj_type = obj_type_e'($urandom_range(0, 3));
    o.center = {$urandom, $urandom, $urandom};
    o.size = size;
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_idx = IW'(idx);
    cfg_obj = o;
    @(negedge clk);
    cfg_we = 1'b0;
    if (idx < N) mdl[idx] = o;
  endtask

  task automatic run_query(input string tag, input logic [N-1:0] mask, input bit chk_lat,
                           input int hold);
    logic [N-1:0] act;
    logic [31:0] e_dist;
    logic [IW-1:0] e_idx;
    logic e_hit;
    int k;
    int c0;
    bit seen, req_seen, stall;
    obj_t p_obj;
    vec3_t p_pos, qpos;
    act = '0;
    e_dist = MAXD;
    e_idx = IW'(N);
    e_hit = 1'b0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      act[i] = mask[i] & mdl[i].en;
      if (act[i]) begin
        k++;
        e_hit = 1'b1;
        if (!(mdl[i].size[30:23] == 8'hFF && mdl[i].size[22:0] != 0) &&
            fkey(mdl[i].size) < fkey(e_dist)) begin
          e_dist = mdl[i].size;
          e_idx = IW'(i);
        end
      end
    end
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    qpos = {$urandom, $urandom, $urandom};
    in_valid = 1'b1;
    obj_mask = mask;
    pos = qpos;
    c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    obj_mask = N'($urandom);
    pos = {$urandom, $urandom, $urandom};
    seen = 0;
    req_seen = 0;
    stall = 0;
    p_obj = '0;
    p_pos = '0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (out_valid) begin
        seen = 1;
      end else begin
        if (stall) begin
          chk({tag, "_stall_valid"}, {31'd0, sdf_req_valid}, 32'd1);
          chk({tag, "_stall_payload"},
              {31'd0, (sdf_req_obj === p_obj) && (sdf_req_pos === p_pos)}, 32'd1);
        end
        if (sdf_req_valid && !req_seen) chk({tag, "_req_pos"}, {31'd0, sdf_req_pos === qpos}, 32'd1);
        req_seen |= sdf_req_valid;
        stall = sdf_req_valid && !sdf_req_ready;
        p_obj = sdf_req_obj;
        p_pos = sdf_req_pos;
        @(negedge clk);
      end
    end
    chk({tag, "_out_valid_seen"}, {31'd0, seen}, 32'd1);
    if (chk_lat) chk({tag, "_latency"}, 32'(cyc - c0), (k == 0) ? 32'd1 : 32'(k + lat + 1));
    if (k == 0) chk({tag, "_no_req"}, {31'd0, req_seen}, 32'd0);
    chk({tag, "_dist"}, closest_dist, e_dist);
    chk({tag, "_idx"}, {28'd0, closest_idx}, {28'd0, e_idx});
    chk({tag, "_hit"}, {31'd0, hit}, {31'd0, e_hit});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      obj_mask = N'($urandom);
      cfg_we = 1'b1;
      cfg_idx = '0;
      cfg_obj = {1'b1, obj_type_e'(2'd1), 96'd0, 32'hC2000000};
      @(negedge clk);
      chk({tag, "_hold_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_cfg_ready"}, {31'd0, cfg_ready}, 32'd0);
      chk({tag, "_hold_dist"}, closest_dist, e_dist);
      chk({tag, "_hold_idx"}, {28'd0, closest_idx}, {28'd0, e_idx});
    end
    in_valid = 1'b0;
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ret_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ret_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, sdf_req_valid}, 32'd0);
    chk("rst_dist", closest_dist, MAXD);
    chk("rst_idx", {28'd0, closest_idx}, 32'd8);
    chk("rst_hit", {31'd0, hit}, 32'd0);

    lat = 1;
    rdy_mode = 0;
    write_cfg(0, 1'b1, 32'hBE4CCCCD);
    run_query("single", 8'h01, 1, 0);

    write_cfg(0, 1'b1, 32'h3F800000);
    write_cfg(1, 1'b1, 32'h3E800000);
    write_cfg(2, 1'b1, 32'h3E800000);
    run_query("tie", 8'h07, 1, 0);

    run_query("empty_mask", 8'h00, 1, 0);
    run_query("empty_en", 8'hF0, 1, 0);

    write_cfg(0, 1'b1, 32'h7FC00000);
    write_cfg(1, 1'b1, 32'h80000000);
    write_cfg(2, 1'b1, 32'h00000000);
    run_query("special", 8'h07, 1, 0);

    write_cfg(9, 1'b1, 32'hC1000000);
    run_query("bad_idx", 8'hFF, 1, 0);

    write_cfg(0, 1'b1, 32'h40000000);
    write_cfg(3, 1'b1, 32'h3F000000);
    rdy_mode = 1;
    lat = 2;
    run_query("bp", 8'h0F, 0, 5);
    rdy_mode = 0;
    run_query("bp_table", 8'h01, 1, 0);

    for (int t = 0; t < 40; t++) begin
      for (int w = $urandom_range(0, 3); w > 0; w--)
        write_cfg($urandom_range(0, N - 1), 1'($urandom_range(0, 4) != 0), rand_fp());
      lat = $urandom_range(0, 3);
      rdy_mode = $urandom_range(0, 2);
      run_query($sformatf("rnd%0d", t), N'($urandom), rdy_mode == 0, 0);
    end

    for (int i = 0; i < 4; i++) write_cfg(i, 1'b1, rand_fp());
    lat = 4;
    rdy_mode = 0;
    @(negedge clk);
    in_valid = 1'b1;
    obj_mask = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_idx", {28'd0, closest_idx}, 32'd8);
    chk("mid_rst_dist", closest_dist, MAXD);
    repeat (4) @(negedge clk);
    chk("late_rsp_out_valid", {31'd0, out_valid}, 32'd0);
    chk("late_rsp_in_ready", {31'd0, in_ready}, 32'd1);
    chk("late_rsp_hit", {31'd0, hit}, 32'd0);
    chk("late_rsp_idx", {28'd0, closest_idx}, 32'd8);
    run_query("post_rst_en", 8'hFF, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
